// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory-access pipeline stage: memory-mode encodings,
// FSM state constants and a small decode helper.
package mem_access_stage_pkg;

  typedef enum logic [1:0] {
    MEM_NOP   = 2'd0,
    MEM_READ  = 2'd1,
    MEM_WRITE = 2'd2,
    MEM_RSVD  = 2'd3
  } memMode_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // The reserved encoding falls through as a NOP, so only READ/WRITE touch memory.
  function automatic logic isMemOp(input logic [1:0] mode);
    return (mode == MEM_READ) || (mode == MEM_WRITE);
  endfunction

endpackage

// File: rtl/mem_access_stage_timeout.sv
// Watchdog for the memory handshake: counts cycles spent in REQ and flags the
// last cycle the stage is allowed to wait for an acknowledge.
module mem_timeout_counter #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Expired on the TIMEOUT-th REQ cycle, so O_mem_req is high exactly TIMEOUT cycles.
  assign expired_o = (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && !expired_o) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage behind the ALU: latches one ALU result, runs an optional
// data-memory req/ack transaction, then presents the write-back payload for one cycle.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                  I_clk,
  input  logic                  I_reset,
  input  logic                  I_enable,
  input  logic [DATA_WIDTH-1:0] I_alu_out,
  input  logic                  I_write_rD,
  input  logic                  I_write_pc,
  input  logic [1:0]            I_memory_mode,
  input  logic [DATA_WIDTH-1:0] I_store_data,
  output logic [ADDR_WIDTH-1:0] O_mem_addr,
  output logic [DATA_WIDTH-1:0] O_mem_wdata,
  output logic                  O_mem_req,
  output logic                  O_mem_we,
  input  logic                  I_mem_ack,
  input  logic [DATA_WIDTH-1:0] I_mem_rdata,
  output logic [DATA_WIDTH-1:0] O_rD_data,
  output logic                  O_write_rD,
  output logic [DATA_WIDTH-1:0] O_pc_data,
  output logic                  O_write_pc,
  output logic                  O_done,
  output logic                  O_busy,
  output logic                  O_error
);

  logic [1:0]            state_q,     state_d;
  logic [DATA_WIDTH-1:0] aluData_q,   aluData_d;
  logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
  logic [DATA_WIDTH-1:0] storeData_q, storeData_d;
  logic [DATA_WIDTH-1:0] readData_q,  readData_d;
  logic [1:0]            mode_q,      mode_d;
  logic                  writeRd_q,   writeRd_d;
  logic                  writePc_q,   writePc_d;
  logic                  error_q,     error_d;

  logic counterClear;
  logic counterEnable;
  logic counterExpired;
  logic inDone;
  logic isWrite;

  assign counterClear  = (state_q == ST_IDLE) && I_enable && isMemOp(I_memory_mode);
  assign counterEnable = (state_q == ST_REQ);

  mem_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk_i     (I_clk),
    .reset_i   (I_reset),
    .clear_i   (counterClear),
    .enable_i  (counterEnable),
    .expired_o (counterExpired)
  );

  // Enable is only honoured in IDLE; a busy stage silently drops new results.
  always_comb begin
    state_d     = state_q;
    aluData_d   = aluData_q;
    addr_d      = addr_q;
    storeData_d = storeData_q;
    readData_d  = readData_q;
    mode_d      = mode_q;
    writeRd_d   = writeRd_q;
    writePc_d   = writePc_q;
    error_d     = error_q;
    case (state_q)
      ST_IDLE: begin
        if (I_enable) begin
          aluData_d   = I_alu_out;
          addr_d      = I_alu_out[ADDR_WIDTH-1:0];
          storeData_d = I_store_data;
          mode_d      = I_memory_mode;
          writeRd_d   = I_write_rD;
          writePc_d   = I_write_pc;
          error_d     = 1'b0;
          state_d     = isMemOp(I_memory_mode) ? ST_REQ : ST_DONE;
        end
      end
      ST_REQ: begin
        // An ack on the final allowed cycle still wins over the timeout.
        if (I_mem_ack) begin
          if (mode_q == MEM_READ) begin
            readData_d = I_mem_rdata;
          end
          state_d = ST_DONE;
        end else if (counterExpired) begin
          error_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      state_q     <= ST_IDLE;
      aluData_q   <= '0;
      addr_q      <= '0;
      storeData_q <= '0;
      readData_q  <= '0;
      mode_q      <= MEM_NOP;
      writeRd_q   <= 1'b0;
      writePc_q   <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      aluData_q   <= aluData_d;
      addr_q      <= addr_d;
      storeData_q <= storeData_d;
      readData_q  <= readData_d;
      mode_q      <= mode_d;
      writeRd_q   <= writeRd_d;
      writePc_q   <= writePc_d;
      error_q     <= error_d;
    end
  end

  assign inDone  = (state_q == ST_DONE);
  assign isWrite = (mode_q == MEM_WRITE);

  assign O_mem_req   = (state_q == ST_REQ);
  assign O_mem_addr  = addr_q;
  assign O_mem_wdata = storeData_q;
  assign O_mem_we    = O_mem_req && isWrite;

  // Write-back buses read as zero outside DONE so downstream never sees stale payload.
  assign O_rD_data  = inDone ? ((mode_q == MEM_READ) ? readData_q : aluData_q) : '0;
  assign O_write_rD = inDone && writeRd_q && !isWrite && !error_q;
  assign O_pc_data  = inDone ? aluData_q : '0;
  assign O_write_pc = inDone && writePc_q && !error_q;
  assign O_done     = inDone;
  assign O_busy     = (state_q != ST_IDLE);
  assign O_error    = inDone && error_q;

endmodule
